// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  mips_pkg : constants, types and helpers shared by the MIPS fetch datapath
//  Rev 1.0  : initial release
// ============================================================================
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int IMEM_IDX_HI = 8;
  localparam int IMEM_IDX_LO = 2;
  localparam int CNT_W_DEF   = 16;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_HOLD     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } ifid_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
//  pc_register : program counter with redirect/stall priority and +4 adder
//  Rev 1.0     : initial release
// ============================================================================
module pc_register
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Pc,
  output logic [31:0] PcPlus4
);

  pc_sel_e     pc_sel;
  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic [31:0] pc_inc;

  // Redirect outranks Stall: a resolved branch makes the stalled fetch moot.
  always_comb begin
    pc_sel = PC_SEQ;
    if (Redirect) begin
      pc_sel = PC_REDIRECT;
    end else if (Stall) begin
      pc_sel = PC_HOLD;
    end
  end

  always_comb begin
    pc_inc = pc_q + PC_STEP;
    pc_d   = pc_inc;
    unique case (pc_sel)
      PC_REDIRECT: pc_d = word_align(RedirectTarget);
      PC_HOLD:     pc_d = pc_q;
      default:     pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Pc      = pc_q;
  assign PcPlus4 = pc_inc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  fetch_stage : MIPS instruction fetch, IF/ID pipeline register and counter
//  Rev 1.0     : initial release
// ============================================================================
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD,
  parameter int          CNT_WIDTH = mips_pkg::CNT_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Redirect,
  input  logic [31:0]          RedirectTarget,
  input  logic                 FlushIFID,
  output logic [31:0]          IMemAddress,
  input  logic [31:0]          IMemInstruction,
  output logic [31:0]          IFID_Instruction,
  output logic [31:0]          IFID_PCPlus4,
  output logic                 IFID_Valid,
  output logic [CNT_WIDTH-1:0] FetchCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [31:0]          pc;
  logic [31:0]          pc_plus4;
  ifid_t                ifid_d;
  ifid_t                ifid_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 load;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Redirect      (Redirect),
    .RedirectTarget(RedirectTarget),
    .Pc            (pc),
    .PcPlus4       (pc_plus4)
  );

  // Flush beats Stall; a Redirect alone still latches the wrong-path fetch.
  always_comb begin
    load   = !FlushIFID && !Stall;
    ifid_d = ifid_q;
    if (FlushIFID) begin
      ifid_d.instr    = NOP_WORD;
      ifid_d.pc_plus4 = '0;
      ifid_d.valid    = 1'b0;
    end else if (!Stall) begin
      ifid_d.instr    = IMemInstruction;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.valid    = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (load && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ifid_q.instr    <= NOP_WORD;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
      count_q         <= '0;
    end else begin
      ifid_q  <= ifid_d;
      count_q <= count_d;
    end
  end

  assign IMemAddress      = pc;
  assign IFID_Instruction = ifid_q.instr;
  assign IFID_PCPlus4     = ifid_q.pc_plus4;
  assign IFID_Valid       = ifid_q.valid;
  assign FetchCount       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  tb_fetch_stage : directed + random stimulus against a behavioural model
//  Rev 1.0        : initial release
// ============================================================================
module tb_fetch_stage;

  localparam int CW      = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Stall;
  logic          Redirect;
  logic [31:0]   RedirectTarget;
  logic          FlushIFID;
  logic [31:0]   IMemAddress;
  logic [31:0]   IMemInstruction;
  logic [31:0]   IFID_Instruction;
  logic [31:0]   IFID_PCPlus4;
  logic          IFID_Valid;
  logic [CW-1:0] FetchCount;

  logic [31:0] mem [128];

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pc4;
  logic        m_v;
  int          m_cnt;

  always #5 Clk = ~Clk;

  assign IMemInstruction = mem[IMemAddress[8:2]];

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .FlushIFID       (FlushIFID),
    .IMemAddress     (IMemAddress),
    .IMemInstruction (IMemInstruction),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid),
    .FetchCount      (FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"},    IMemAddress,            m_pc);
    chk({ctx, ".instr"}, IFID_Instruction,       m_ins);
    chk({ctx, ".pc4"},   IFID_PCPlus4,           m_pc4);
    chk({ctx, ".valid"}, {31'd0, IFID_Valid},    {31'd0, m_v});
    chk({ctx, ".count"}, 32'(FetchCount),        32'(m_cnt));
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_ins = 32'h0;
    m_pc4 = 32'h0;
    m_v   = 1'b0;
    m_cnt = 0;
  endtask

  task automatic drive(input logic s, input logic r, input logic f, input logic [31:0] t);
    Stall          = s;
    Redirect       = r;
    FlushIFID      = f;
    RedirectTarget = t;
  endtask

  // Advance the reference one clock edge from the present inputs, then compare.
  task automatic step(input string ctx);
    logic [31:0] npc;
    if (Reset) begin
      model_reset();
    end else begin
      if (Redirect)   npc = RedirectTarget & 32'hFFFF_FFFC;
      else if (Stall) npc = m_pc;
      else            npc = m_pc + 32'd4;
      if (FlushIFID) begin
        m_ins = 32'h0;
        m_pc4 = 32'h0;
        m_v   = 1'b0;
      end else if (!Stall) begin
        m_ins = mem[m_pc[8:2]];
        m_pc4 = m_pc + 32'd4;
        m_v   = 1'b1;
        if (m_cnt < CNT_SAT) m_cnt++;
      end
      m_pc = npc;
    end
    @(posedge Clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 3;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    model_reset();
    check_all("reset");

    @(negedge Clk);
    Reset = 1'b0;
    step("run0");
    chk("run0.instr_abs", IFID_Instruction, 32'd0);
    chk("run0.pc4_abs",   IFID_PCPlus4,     32'd4);
    step("run1");

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step("stall0");
    step("stall1");
    chk("stall.pc_abs",    IMemAddress,      32'd8);
    chk("stall.instr_abs", IFID_Instruction, 32'd3);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("release0");
    chk("release.instr_abs", IFID_Instruction, 32'd6);
    chk("release.pc4_abs",   IFID_PCPlus4,     32'd12);
    step("release1");
    chk("run.count_abs", 32'(FetchCount), 32'd4);

    drive(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    step("redir_flush");
    chk("redir_flush.pc_abs", IMemAddress, 32'h40);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("after_redir");
    chk("after_redir.instr_abs", IFID_Instruction, 32'd48);
    chk("after_redir.pc4_abs",   IFID_PCPlus4,     32'h44);

    drive(1'b1, 1'b1, 1'b1, 32'h0000_0020);
    step("all_three");
    chk("all_three.pc_abs", IMemAddress, 32'h20);

    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step("to_top");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("wrap");
    chk("wrap.pc_abs",  IMemAddress,  32'h0);
    chk("wrap.pc4_abs", IFID_PCPlus4, 32'h0);

    for (int i = 0; i < 20; i++) step("saturate");
    chk("saturate.count_abs", 32'(FetchCount), CNT_SAT);

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step("pre_async");
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge Clk);
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("post_async");

    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(99) < 25, $urandom_range(99) < 15,
            $urandom_range(99) < 15, $urandom());
      Reset = ($urandom_range(99) < 2);
      step("random");
    end
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
